// File: rtl/axi_timer_slave_pkg.sv
// Shared constants, FSM state types and address decode for the AXI machine-timer responder.
package axi_timer_slave_pkg;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;
  typedef enum logic [1:0] {REG_NONE, REG_MSIP, REG_MTIMECMP, REG_MTIME} reg_sel_e;

  // Registers are 64-bit words, so only the word index addr[15:3] matters.
  function automatic reg_sel_e decode_reg(input logic [15:0] addr);
    if (addr[15:3] == MSIP_OFF[15:3])     return REG_MSIP;
    if (addr[15:3] == MTIMECMP_OFF[15:3]) return REG_MTIMECMP;
    if (addr[15:3] == MTIME_OFF[15:3])    return REG_MTIME;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/axi_timer_slave_burst_addr.sv
// Next-beat address for an AXI burst; WRAP is treated as INCR.
module axi_burst_addr
  import axi_timer_slave_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] incr;

  always_comb begin
    incr = ADDR_W'(1) << size;
    case (burst)
      BURST_FIXED:            next_addr = addr;
      BURST_INCR, BURST_WRAP: next_addr = addr + incr;
      default:                next_addr = addr + incr;
    endcase
  end

endmodule

// File: rtl/axi_timer_slave.sv
// AXI4 responder for msip/mtimecmp/mtime with timer and software interrupt outputs.
module axi_timer_slave
  import axi_timer_slave_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int ID_W     = 4,
  parameter int TICK_DIV = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                awvalid_timer,
  output logic                awready_timer,
  input  logic [ID_W-1:0]     awid_timer,
  input  logic [ADDR_W-1:0]   awaddr_timer,
  input  logic [7:0]          awlen_timer,
  input  logic [2:0]          awsize_timer,
  input  logic [1:0]          awburst_timer,
  input  logic                wvalid_timer,
  output logic                wready_timer,
  input  logic [DATA_W-1:0]   wdata_timer,
  input  logic [DATA_W/8-1:0] wstrb_timer,
  input  logic                wlast_timer,
  output logic                bvalid_timer,
  input  logic                bready_timer,
  output logic [ID_W-1:0]     bid_timer,
  output logic [1:0]          bresp_timer,
  input  logic                arvalid_timer,
  output logic                arready_timer,
  input  logic [ID_W-1:0]     arid_timer,
  input  logic [ADDR_W-1:0]   araddr_timer,
  input  logic [7:0]          arlen_timer,
  input  logic [2:0]          arsize_timer,
  input  logic [1:0]          arburst_timer,
  output logic                rvalid_timer,
  input  logic                rready_timer,
  output logic [ID_W-1:0]     rid_timer,
  output logic [DATA_W-1:0]   rdata_timer,
  output logic [1:0]          rresp_timer,
  output logic                rlast_timer,
  output logic                timer_irq_o,
  output logic                soft_irq_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  wr_state_e w_state, w_state_nxt;
  rd_state_e r_state, r_state_nxt;

  logic [ID_W-1:0]   aw_id;
  logic [ADDR_W-1:0] aw_addr, aw_addr_nxt;
  logic [7:0]        aw_len, w_cnt;
  logic [2:0]        aw_size;
  logic [1:0]        aw_burst;
  logic              w_err;

  logic [ADDR_W-1:0] ar_addr, ar_addr_nxt;
  logic [7:0]        ar_len, r_cnt;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;

  logic [DATA_W-1:0] mtime, mtimecmp;
  logic              msip;
  logic [PRE_W-1:0]  presc;
  logic              tick;

  logic              aw_fire, w_fire, ar_fire, r_fire;
  logic              w_last_beat, w_beat_err;
  reg_sel_e          w_sel, rd_sel;
  logic [15:0]       rd_addr;
  logic [DATA_W-1:0] rd_word;
  logic [1:0]        rd_resp;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old,
                                                    input logic [DATA_W-1:0] data,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] m;
    m = old;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) m[8*i +: 8] = data[8*i +: 8];
    end
    return m;
  endfunction

  axi_burst_addr #(.ADDR_W(ADDR_W)) u_aw_next (
    .addr(aw_addr), .size(aw_size), .burst(aw_burst), .next_addr(aw_addr_nxt)
  );

  axi_burst_addr #(.ADDR_W(ADDR_W)) u_ar_next (
    .addr(ar_addr), .size(ar_size), .burst(ar_burst), .next_addr(ar_addr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  // Ready outputs are gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    w_state_nxt   = w_state;
    awready_timer = 1'b0;
    wready_timer  = 1'b0;
    bvalid_timer  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready_timer = rst_n;
        if (awvalid_timer) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        wready_timer = 1'b1;
        if (wvalid_timer && w_last_beat) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        bvalid_timer = 1'b1;
        if (bready_timer) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt   = r_state;
    arready_timer = 1'b0;
    rvalid_timer  = 1'b0;
    rlast_timer   = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready_timer = rst_n;
        if (arvalid_timer) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        rvalid_timer = 1'b1;
        rlast_timer  = (r_cnt == ar_len);
        if (rready_timer && rlast_timer) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign aw_fire     = awvalid_timer && awready_timer;
  assign w_fire      = wvalid_timer && wready_timer;
  assign ar_fire     = arvalid_timer && arready_timer;
  assign r_fire      = rvalid_timer && rready_timer;
  assign w_last_beat = (w_cnt == aw_len);
  assign w_sel       = decode_reg(aw_addr[15:0]);
  assign w_beat_err  = (w_sel == REG_NONE) || (wlast_timer != w_last_beat);
  assign tick        = (presc == PRE_W'(TICK_DIV - 1));

  // Read mux sees register values before this cycle's write, so a coincident write is not visible.
  always_comb begin
    rd_addr = (r_state == R_IDLE) ? araddr_timer[15:0] : ar_addr_nxt[15:0];
    rd_sel  = decode_reg(rd_addr);
    rd_resp = AXI_RESP_OKAY;
    case (rd_sel)
      REG_MSIP:     rd_word = {{(DATA_W-1){1'b0}}, msip};
      REG_MTIMECMP: rd_word = mtimecmp;
      REG_MTIME:    rd_word = mtime;
      default: begin
        rd_word = '0;
        rd_resp = AXI_RESP_SLVERR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_id       <= '0;
      aw_addr     <= '0;
      aw_len      <= '0;
      aw_size     <= '0;
      aw_burst    <= '0;
      w_cnt       <= '0;
      w_err       <= 1'b0;
      bid_timer   <= '0;
      bresp_timer <= AXI_RESP_OKAY;
    end else begin
      if (aw_fire) begin
        aw_id    <= awid_timer;
        aw_addr  <= awaddr_timer;
        aw_len   <= awlen_timer;
        aw_size  <= awsize_timer;
        aw_burst <= awburst_timer;
        w_cnt    <= '0;
        w_err    <= 1'b0;
      end
      if (w_fire) begin
        aw_addr <= aw_addr_nxt;
        w_cnt   <= w_cnt + 8'd1;
        w_err   <= w_err | w_beat_err;
        if (w_last_beat) begin
          bid_timer   <= aw_id;
          bresp_timer <= (w_err | w_beat_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_addr     <= '0;
      ar_len      <= '0;
      ar_size     <= '0;
      ar_burst    <= '0;
      r_cnt       <= '0;
      rid_timer   <= '0;
      rdata_timer <= '0;
      rresp_timer <= AXI_RESP_OKAY;
    end else if (ar_fire) begin
      ar_addr     <= araddr_timer;
      ar_len      <= arlen_timer;
      ar_size     <= arsize_timer;
      ar_burst    <= arburst_timer;
      r_cnt       <= '0;
      rid_timer   <= arid_timer;
      rdata_timer <= rd_word;
      rresp_timer <= rd_resp;
    end else if (r_fire && !rlast_timer) begin
      ar_addr     <= ar_addr_nxt;
      r_cnt       <= r_cnt + 8'd1;
      rdata_timer <= rd_word;
      rresp_timer <= rd_resp;
    end
  end

  // A bus write to mtime swallows a coincident tick; the prescaler keeps running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime       <= '0;
      mtimecmp    <= '1;
      msip        <= 1'b0;
      presc       <= '0;
      timer_irq_o <= 1'b0;
      soft_irq_o  <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PRE_W'(1);
      if (w_fire && (w_sel == REG_MSIP) && wstrb_timer[0]) msip <= wdata_timer[0];
      if (w_fire && (w_sel == REG_MTIMECMP))
        mtimecmp <= merge_bytes(mtimecmp, wdata_timer, wstrb_timer);
      if (w_fire && (w_sel == REG_MTIME))
        mtime <= merge_bytes(mtime, wdata_timer, wstrb_timer);
      else if (tick)
        mtime <= mtime + DATA_W'(1);
      timer_irq_o <= (mtime >= mtimecmp);
      soft_irq_o  <= msip;
    end
  end

endmodule

// File: doc/axi_timer_slave.md
# axi_timer_slave

AXI4 responder implementing the machine-timer and software-interrupt registers (msip, mtimecmp, mtime) for the pipeline core. It answers single-beat and burst reads and writes that the interconnect routes to its timer port, and drives the timer and software interrupt lines back to the core. One write and one read transaction can be in flight at the same time, at most one of each.

## Interface
Parameters:
- ADDR_W, 64, AXI address width; only addr[15:0] is decoded.
- DATA_W, 64, data width; the strobe is DATA_W/8 bits.
- ID_W, 4, AXI ID width.
- TICK_DIV, 1, clk cycles per mtime increment; must be ≥1.

Ports (clock and reset first):
- clk  in  1  single clock domain; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- awvalid_timer  in  1  write-address valid.
- awready_timer  out  1  write-address ready.
- awid_timer  in  ID_W  write ID.
- awaddr_timer  in  ADDR_W  write address.
- awlen_timer  in  8  beats minus 1.
- awsize_timer  in  3  log2 of bytes per beat.
- awburst_timer  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP.
- wvalid_timer  in  1  write-data valid.
- wready_timer  out  1  write-data ready.
- wdata_timer  in  DATA_W  write data.
- wstrb_timer  in  DATA_W/8  byte strobes.
- wlast_timer  in  1  last write beat.
- bvalid_timer  out  1  write-response valid.
- bready_timer  in  1  write-response ready.
- bid_timer  out  ID_W  echoed AWID.
- bresp_timer  out  2  00 OKAY, 10 SLVERR.
- arvalid_timer  in  1  read-address valid.
- arready_timer  out  1  read-address ready.
- arid_timer, araddr_timer, arlen_timer, arsize_timer, arburst_timer  in  same widths as AW  read address channel.
- rvalid_timer  out  1  read-data valid.
- rready_timer  in  1  read-data ready.
- rid_timer  out  ID_W  echoed ARID.
- rdata_timer  out  DATA_W  read data.
- rresp_timer  out  2  read response.
- rlast_timer  out  1  last read beat.
- timer_irq_o  out  1  high when mtime ≥ mtimecmp, unsigned compare.
- soft_irq_o  out  1  equals msip[0].

## Operation
Register map, decoded on addr[15:3] (the 64-bit word index):
- 0x0000 msip: only bit 0 is writable; all other bits read 0.
- 0x4000 mtimecmp: 64-bit read/write.
- 0xBFF8 mtime: 64-bit read/write.
- Any other address is unmapped.

Write FSM (W_IDLE → W_DATA → W_RESP):
- W_IDLE: awready=1. On the AW handshake, latch id, addr, len, size and burst, clear the beat count, then go to W_DATA.
- W_DATA: wready=1. On each W handshake:
  - Merge wdata into the addressed register, byte by byte, per wstrb.
  - An unmapped address discards the data and sets a sticky SLVERR.
  - Then advance the address.
- Leave W_DATA on the beat where beat count == len. If wlast disagrees with that beat count (early or missing), set SLVERR.
- W_RESP: bvalid=1, hold until bready, then return to W_IDLE.

Read FSM (R_IDLE → R_DATA):
- R_IDLE: arready=1. On the AR handshake, latch the channel, load rdata/rresp for beat 0, then go to R_DATA.
- R_DATA: rvalid=1, and rlast=(beat count == len).
- On each R handshake:
  - If rlast, return to R_IDLE.
  - Otherwise advance the address and reload rdata/rresp from the new address.
- rdata and rresp are registered and stay stable while rvalid=1 and rready=0, even while mtime keeps ticking.
- Unmapped read: rdata=0, rresp=SLVERR.

Address advance:
- INCR: addr += 1<<size.
- FIXED: addr is unchanged.
- WRAP: treated as INCR.

mtime:
- Increments by 1 every TICK_DIV cycles through a prescaler counter.
- Wraps from 2^64−1 to 0.
- A bus write to mtime in the same cycle as a tick wins: the written bytes take the written value and the tick is dropped for that cycle. The prescaler is not reset.

## Timing
- Reset values: awready=wready=arready=0 during reset and 1 in the first cycle after release (idle states). bvalid=rvalid=rlast=0. bid=rid=0, bresp=rresp=0, rdata=0. mtime=0, mtimecmp=all-ones, msip=0, prescaler=0, so timer_irq_o=0 and soft_irq_o=0.
- Read latency: AR handshake in cycle N gives rvalid in cycle N+1. Back-to-back beats are possible when rready is held high.
- Write: the last W handshake in cycle N gives bvalid in cycle N+1. The register update is visible to a read launched in cycle N+1.
- timer_irq_o and soft_irq_o are registered; they reflect register state one cycle after any update.
- AW and AR are accepted independently, so reads and writes may overlap. A read beat loaded in the same cycle as a write to the same register returns the old value.
- Reset asserted mid-transaction aborts both FSMs to idle and all registers to their reset values. No response is issued for the aborted transaction.

## Structure
- Shared package holds the register offsets (MSIP_OFF, MTIMECMP_OFF, MTIME_OFF), the AXI_RESP_OKAY/SLVERR and burst-type constants, and the write/read FSM state enums.
- Sub-module axi_burst_addr (next-address calculator: addr, size, burst → next addr), instantiated once per channel.

## Test plan
- Single-beat write of 0x0000_0000_0000_0010 to 0x4000 with strb 0xFF → bresp=00, bid=awid. A following read of 0x4000 returns 0x10 with rlast=1.
- TICK_DIV=1, mtimecmp=5 → timer_irq_o rises in the cycle after mtime reaches 5. Writing mtimecmp=all-ones deasserts it one cycle after the write.
- INCR read, len=1, size=3, starting at 0x4000 → beat 0 returns mtimecmp with OKAY. Beat 1 (0x4008, unmapped) returns rdata=0, rresp=10, rlast=1. Holding rready=0 for 3 cycles keeps rdata stable.
- Write 0x1 to 0x0000 with strb 0x01 → soft_irq_o=1. Write with strb 0x00 → no change.
- Write mtime with TICK_DIV=1, wdata=0xFFFF_FFFF_FFFF_FFFF → the next tick reads 0, and the written value wins over the coincident tick. Also: a burst with an early wlast gives bresp=10.
- Assert rst_n low mid-burst → all outputs return to their reset values. The first transaction after release completes normally.
